// File: rtl/block_sync_66.sv
// 10GBASE-R block lock engine: hunts for 66-bit alignment via gearbox slips and reports block lock.
// Optional high-BER monitor is compiled in with `define BLOCK_SYNC_HIBER_EN.
module block_sync_66 #(
    parameter int LOCK_CNT     = 64,
    parameter int INVALID_MAX  = 16,
    parameter int SLIP_WAIT    = 32,
    parameter int HIBER_WINDOW = 40283,
    parameter int HIBER_THRESH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] head_i,
    input  logic       head_valid_i,
    output logic       slip_o,
    output logic       block_lock_o,
    output logic       hi_ber_o
);

    localparam int SH_W   = $clog2(LOCK_CNT + 1);
    localparam int INV_W  = $clog2(INVALID_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(LOCK_CNT - 1);
    localparam logic [SH_W-1:0]   SH_ONE    = SH_W'(1);
    localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(INVALID_MAX - 1);
    localparam logic [INV_W-1:0]  INV_ONE   = INV_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef enum logic [1:0] {
        RESET_CNT,
        TEST,
        SLIP,
        WAIT
    } state_t;

    state_t state, state_nxt;

    logic [SH_W-1:0]   sh_cnt, sh_cnt_nxt;
    logic [INV_W-1:0]  inv_cnt, inv_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              slip_nxt;
    logic              lock_nxt;
    logic              head_bad;
    logic              slip_req;
    logic              window_done;

    assign head_bad = (head_i == 2'b00) || (head_i == 2'b11);

    // An invalid header slips at once while hunting; once locked it takes INVALID_MAX per window.
    assign slip_req    = head_bad && (!block_lock_o || (inv_cnt == INV_LAST));
    assign window_done = (sh_cnt == SH_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= RESET_CNT;
            sh_cnt       <= '0;
            inv_cnt      <= '0;
            wait_cnt     <= '0;
            slip_o       <= 1'b0;
            block_lock_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            sh_cnt       <= sh_cnt_nxt;
            inv_cnt      <= inv_cnt_nxt;
            wait_cnt     <= wait_cnt_nxt;
            slip_o       <= slip_nxt;
            block_lock_o <= lock_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sh_cnt_nxt   = sh_cnt;
        inv_cnt_nxt  = inv_cnt;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RESET_CNT: begin
                sh_cnt_nxt  = '0;
                inv_cnt_nxt = '0;
                state_nxt   = TEST;
            end
            TEST: begin
                if (head_valid_i) begin
                    sh_cnt_nxt = sh_cnt + SH_ONE;
                    if (head_bad) begin
                        inv_cnt_nxt = inv_cnt + INV_ONE;
                    end
                    if (slip_req) begin
                        state_nxt = SLIP;
                    end else if (window_done) begin
                        state_nxt = RESET_CNT;
                    end
                end
            end
            SLIP: begin
                wait_cnt_nxt = '0;
                state_nxt    = WAIT;
            end
            WAIT: begin
                // Header values are meaningless until the gearbox has realigned.
                if (head_valid_i) begin
                    wait_cnt_nxt = wait_cnt + WAIT_ONE;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = RESET_CNT;
                    end
                end
            end
            default: state_nxt = RESET_CNT;
        endcase
    end

    always_comb begin
        slip_nxt = (state_nxt == SLIP);
        lock_nxt = block_lock_o;
        if (state_nxt == SLIP) begin
            lock_nxt = 1'b0;
        end else if ((state == TEST) && head_valid_i && window_done &&
                     (inv_cnt == '0) && !head_bad) begin
            lock_nxt = 1'b1;
        end
    end

`ifdef BLOCK_SYNC_HIBER_EN
    localparam int WIN_W = (HIBER_WINDOW > 1) ? $clog2(HIBER_WINDOW) : 1;
    localparam int BER_W = $clog2(HIBER_THRESH + 1);

    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(HIBER_WINDOW - 1);
    localparam logic [WIN_W-1:0] WIN_ONE    = WIN_W'(1);
    localparam logic [BER_W-1:0] BER_THRESH = BER_W'(HIBER_THRESH);
    localparam logic [BER_W-1:0] BER_ONE    = BER_W'(1);

    logic [WIN_W-1:0] win_cnt;
    logic [BER_W-1:0] ber_cnt;
    logic             ber_hit;
    logic             win_end;

    assign ber_hit = head_valid_i && head_bad && (state != WAIT);
    assign win_end = (win_cnt == WIN_LAST);

    // A header landing on the window-end cycle belongs to the window that starts next.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_cnt  <= '0;
            ber_cnt  <= '0;
            hi_ber_o <= 1'b0;
        end else begin
            win_cnt <= win_end ? '0 : (win_cnt + WIN_ONE);
            if (win_end) begin
                hi_ber_o <= (ber_cnt >= BER_THRESH);
                ber_cnt  <= ber_hit ? BER_ONE : '0;
            end else if (ber_hit && (ber_cnt != BER_THRESH)) begin
                ber_cnt <= ber_cnt + BER_ONE;
            end
        end
    end
`else
    // BER monitor compiled out; the parameters stay so instantiations remain portable.
    assign hi_ber_o = (HIBER_WINDOW < 0) && (HIBER_THRESH < 0);
`endif

endmodule
